// File: rtl/pl_dmem_arbiter.sv
// Arbitrates one single-port data RAM between the CPU MEM stage and a DMA/loader port.
// Each access is a grant cycle in IDLE plus one BUSY cycle; the DMA is forced in after STARVE_LIMIT lost rounds.
module pl_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [31:0] cpu_rdata_q;
    logic [31:0] dma_rdata_q;
    logic        cpu_win;
    logic        dma_win;

    assign cpu_win = (state == IDLE) && cpu_req && (wait_cnt < LIMIT);
    assign dma_win = (state == IDLE) && !cpu_win && dma_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_win) begin
                    state_nxt = BUSY_CPU;
                end else if (dma_win) begin
                    state_nxt = BUSY_DMA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY_CPU: state_nxt = IDLE;
            BUSY_DMA: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Memory port is only driven in the grant cycle; BUSY cycles just collect read data.
    always_comb begin
        mem_addr   = 32'd0;
        mem_datain = 32'd0;
        mem_we     = 1'b0;
        if (cpu_win) begin
            mem_addr   = cpu_addr;
            mem_datain = cpu_wdata;
            mem_we     = cpu_we;
        end else if (dma_win) begin
            mem_addr   = dma_addr;
            mem_datain = dma_wdata;
            mem_we     = dma_we;
        end
        cpu_stall = cpu_req && (state != BUSY_CPU);
        cpu_rdata = (state == BUSY_CPU) ? mem_dataout : cpu_rdata_q;
        // Reset in the BUSY_DMA cycle aborts the access, so the ack is suppressed.
        dma_ack   = (state == BUSY_DMA) && !reset;
        dma_rdata = dma_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt    <= 4'd0;
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
        end else begin
            if (state == BUSY_CPU) begin
                cpu_rdata_q <= mem_dataout;
            end
            if (state == BUSY_DMA) begin
                dma_rdata_q <= mem_dataout;
            end
            if (!dma_req || dma_win) begin
                wait_cnt <= 4'd0;
            end else if (cpu_win && (wait_cnt < LIMIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pl_dmem_arbiter.sv
// Bench for pl_dmem_arbiter: behavioural RAM with one-cycle read latency, per-requester
// queues of expected completions filled as requests are driven and drained as they complete.
module tb_pl_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } sb_t;

    sb_t         cpu_q[$];
    sb_t         dma_q[$];
    logic [31:0] ram     [32];
    logic [31:0] exp_mem [32];
    int          vectors;
    int          miscompares;

    pl_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_rdata   (dma_rdata),
        .dma_ack     (dma_ack),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: read-before-write, data valid the cycle after the address.
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr[6:2]] <= mem_datain;
        mem_dataout <= ram[mem_addr[6:2]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h10;
        tick(); tick();
        #1;
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b want 1", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        vectors++; if (dma_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_dma_rdata: got %h want 0", dma_rdata); end
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL reset_dma_ack: got %b want 0", dma_ack); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (dut.wait_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_wait_cnt: got %0d want 0", dut.wait_cnt); end
        cpu_req = 1'b0; cpu_addr = 32'h0;
        #1;
        vectors++; if (mem_addr !== 32'd0 || mem_datain !== 32'd0) begin miscompares++; $display("FAIL idle_bus: got addr %h data %h want 0/0", mem_addr, mem_datain); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL idle_stall: got %b want 0", cpu_stall); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        sb_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        cpu_q.push_back('{we: 1'b0, data: exp_mem[4]});
        #1;
        vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL cpu_rd_addr: got %h want 10", mem_addr); end
        vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("FAIL cpu_rd_stall0: got %b want 1", cpu_stall); end
        tick(); #1;
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("FAIL cpu_rd_stall1: got %b want 0", cpu_stall); end
        e = cpu_q.pop_front();
        vectors++; if (cpu_rdata !== e.data) begin miscompares++; $display("FAIL cpu_rd_data: got %h want %h", cpu_rdata, e.data); end
        tick();
        cpu_req = 1'b0;
        #1;
        vectors++; if (cpu_rdata !== e.data) begin miscompares++; $display("FAIL cpu_rd_hold: got %h want %h", cpu_rdata, e.data); end
        vectors++; if (cpu_q.size() != 0) begin miscompares++; $display("FAIL cpu_rd_drain: got %0d left want 0", cpu_q.size()); end
        tick();
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h08; dma_wdata = 32'h12345678;
        exp_mem[2] = 32'h12345678;
        dma_q.push_back('{we: 1'b1, data: 32'd0});
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_addr !== 32'h08 || mem_datain !== 32'h12345678) begin miscompares++; $display("FAIL dma_wr_grant: got we %b addr %h data %h want 1/08/12345678", mem_we, mem_addr, mem_datain); end
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL dma_wr_early_ack: got %b want 0", dma_ack); end
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        #1;
        vectors++; if (dma_ack !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL dma_wr_ack: got ack %b we %b want 1/0", dma_ack, mem_we); end
        void'(dma_q.pop_front());
        tick(); #1;
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL dma_wr_ack_pulse: got %b want 0", dma_ack); end
        vectors++; if (ram[2] !== exp_mem[2]) begin miscompares++; $display("FAIL dma_wr_ram: got %h want %h", ram[2], exp_mem[2]); end
        vectors++; if (dma_q.size() != 0) begin miscompares++; $display("FAIL dma_wr_drain: got %0d left want 0", dma_q.size()); end
        tick();
    endtask

    task automatic test_priority();
        sb_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h08;
        cpu_q.push_back('{we: 1'b0, data: exp_mem[4]});
        dma_q.push_back('{we: 1'b0, data: exp_mem[2]});
        #1;
        vectors++; if (mem_addr !== 32'h10 || cpu_stall !== 1'b1) begin miscompares++; $display("FAIL prio_cpu_first: got addr %h stall %b want 10/1", mem_addr, cpu_stall); end
        tick(); #1;
        e = cpu_q.pop_front();
        vectors++; if (cpu_stall !== 1'b0 || cpu_rdata !== e.data) begin miscompares++; $display("FAIL prio_cpu_data: got stall %b data %h want 0/%h", cpu_stall, cpu_rdata, e.data); end
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL prio_ack_c1: got %b want 0", dma_ack); end
        tick();
        cpu_req = 1'b0;
        #1;
        vectors++; if (mem_addr !== 32'h08 || dma_ack !== 1'b0) begin miscompares++; $display("FAIL prio_dma_grant: got addr %h ack %b want 08/0", mem_addr, dma_ack); end
        vectors++; if (dut.wait_cnt !== 4'd1) begin miscompares++; $display("FAIL prio_wait_cnt: got %0d want 1", dut.wait_cnt); end
        tick(); #1;
        vectors++; if (dma_ack !== 1'b1) begin miscompares++; $display("FAIL prio_ack_c3: got %b want 1", dma_ack); end
        e = dma_q.pop_front();
        dma_req = 1'b0;
        tick(); #1;
        vectors++; if (dma_rdata !== e.data) begin miscompares++; $display("FAIL prio_dma_data: got %h want %h", dma_rdata, e.data); end
        vectors++; if (dut.wait_cnt !== 4'd0) begin miscompares++; $display("FAIL prio_wait_clr: got %0d want 0", dut.wait_cnt); end
        tick();
    endtask

    task automatic test_starvation();
        sb_t         e;
        logic [31:0] dma_exp;
        bit          dma_pend;
        int          p;
        dma_pend = 1'b0;
        dma_exp  = 32'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h08;
        for (int i = 0; i < 8; i++) cpu_q.push_back('{we: 1'b0, data: exp_mem[4]});
        for (int i = 0; i < 2; i++) dma_q.push_back('{we: 1'b0, data: exp_mem[2]});
        #1;
        for (int k = 0; k < 20; k++) begin
            p = k % 10;
            if (dma_pend) begin
                dma_pend = 1'b0;
                vectors++; if (dma_rdata !== dma_exp) begin miscompares++; $display("FAIL starve_dma_data c%0d: got %h want %h", k, dma_rdata, dma_exp); end
                vectors++; if (dut.wait_cnt !== 4'd0) begin miscompares++; $display("FAIL starve_wait_clr c%0d: got %0d want 0", k, dut.wait_cnt); end
            end
            if (p < 8 && p % 2 == 0) begin
                vectors++; if (mem_addr !== 32'h10 || cpu_stall !== 1'b1) begin miscompares++; $display("FAIL starve_cpu_grant c%0d: got addr %h stall %b want 10/1", k, mem_addr, cpu_stall); end
            end else if (p < 8) begin
                e = cpu_q.pop_front();
                vectors++; if (cpu_stall !== 1'b0 || cpu_rdata !== e.data || dma_ack !== 1'b0) begin miscompares++; $display("FAIL starve_cpu_busy c%0d: got stall %b data %h ack %b want 0/%h/0", k, cpu_stall, cpu_rdata, dma_ack, e.data); end
            end else if (p == 8) begin
                vectors++; if (mem_addr !== 32'h08 || cpu_stall !== 1'b1 || dut.wait_cnt !== 4'd4) begin miscompares++; $display("FAIL starve_dma_grant c%0d: got addr %h stall %b wait %0d want 08/1/4", k, mem_addr, cpu_stall, dut.wait_cnt); end
            end else begin
                vectors++; if (dma_ack !== 1'b1 || cpu_stall !== 1'b1) begin miscompares++; $display("FAIL starve_dma_ack c%0d: got ack %b stall %b want 1/1", k, dma_ack, cpu_stall); end
                e = dma_q.pop_front();
                dma_exp  = e.data;
                dma_pend = 1'b1;
            end
            tick(); #1;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        vectors++; if (dma_rdata !== dma_exp) begin miscompares++; $display("FAIL starve_dma_last: got %h want %h", dma_rdata, dma_exp); end
        vectors++; if (cpu_q.size() != 0 || dma_q.size() != 0) begin miscompares++; $display("FAIL starve_drain: got %0d/%0d left want 0/0", cpu_q.size(), dma_q.size()); end
        tick();
    endtask

    task automatic test_back_to_back();
        sb_t e;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'hA5A50001;
        exp_mem[6] = 32'hA5A50001;
        cpu_q.push_back('{we: 1'b1, data: 32'd0});
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_datain !== 32'hA5A50001) begin miscompares++; $display("FAIL b2b_wr_grant: got we %b data %h want 1/a5a50001", mem_we, mem_datain); end
        tick(); #1;
        vectors++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_busy: got we %b stall %b want 0/0", mem_we, cpu_stall); end
        void'(cpu_q.pop_front());
        tick();
        cpu_we = 1'b0;
        cpu_q.push_back('{we: 1'b0, data: exp_mem[6]});
        #1;
        vectors++; if (mem_addr !== 32'h18 || mem_we !== 1'b0 || cpu_stall !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_grant: got addr %h we %b stall %b want 18/0/1", mem_addr, mem_we, cpu_stall); end
        tick(); #1;
        e = cpu_q.pop_front();
        vectors++; if (cpu_rdata !== e.data) begin miscompares++; $display("FAIL b2b_rd_data: got %h want %h", cpu_rdata, e.data); end
        tick();
        cpu_req = 1'b0;
        #1;
        vectors++; if (cpu_rdata !== e.data) begin miscompares++; $display("FAIL b2b_rd_hold: got %h want %h", cpu_rdata, e.data); end
        tick();
    endtask

    task automatic test_dropped_request();
        sb_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h14; dma_wdata = 32'hBAD0BAD0;
        cpu_q.push_back('{we: 1'b0, data: exp_mem[4]});
        #1;
        vectors++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin miscompares++; $display("FAIL drop_grant: got addr %h we %b want 10/0", mem_addr, mem_we); end
        tick();
        dma_req = 1'b0;
        #1;
        e = cpu_q.pop_front();
        vectors++; if (cpu_rdata !== e.data || dma_ack !== 1'b0) begin miscompares++; $display("FAIL drop_cpu_busy: got data %h ack %b want %h/0", cpu_rdata, dma_ack, e.data); end
        tick();
        cpu_req = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'd0 || dma_ack !== 1'b0) begin miscompares++; $display("FAIL drop_no_grant: got we %b addr %h ack %b want 0/0/0", mem_we, mem_addr, dma_ack); end
        vectors++; if (dut.wait_cnt !== 4'd0) begin miscompares++; $display("FAIL drop_wait_cnt: got %0d want 0", dut.wait_cnt); end
        tick(); #1;
        vectors++; if (dma_ack !== 1'b0 || ram[5] !== exp_mem[5]) begin miscompares++; $display("FAIL drop_no_effect: got ack %b ram5 %h want 0/%h", dma_ack, ram[5], exp_mem[5]); end
        tick();
    endtask

    task automatic test_reset_in_busy_dma();
        sb_t e;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h08;
        dma_q.push_back('{we: 1'b0, data: exp_mem[2]});
        #1;
        vectors++; if (mem_addr !== 32'h08) begin miscompares++; $display("FAIL rstdma_grant: got %h want 08", mem_addr); end
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL rstdma_no_ack: got %b want 0", dma_ack); end
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (dma_rdata !== 32'd0) begin miscompares++; $display("FAIL rstdma_rdata_clr: got %h want 0", dma_rdata); end
        vectors++; if (mem_addr !== 32'h08 || dma_ack !== 1'b0) begin miscompares++; $display("FAIL rstdma_regrant: got addr %h ack %b want 08/0", mem_addr, dma_ack); end
        tick(); #1;
        vectors++; if (dma_ack !== 1'b1) begin miscompares++; $display("FAIL rstdma_ack: got %b want 1", dma_ack); end
        e = dma_q.pop_front();
        dma_req = 1'b0;
        tick(); #1;
        vectors++; if (dma_rdata !== e.data || dma_ack !== 1'b0) begin miscompares++; $display("FAIL rstdma_data: got %h ack %b want %h/0", dma_rdata, dma_ack, e.data); end
        vectors++; if (dma_q.size() != 0) begin miscompares++; $display("FAIL rstdma_drain: got %0d left want 0", dma_q.size()); end
        tick();
    endtask

    task automatic test_reset_write_grant();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1C; cpu_wdata = 32'hCAFEF00D;
        exp_mem[7] = 32'hCAFEF00D;
        #1;
        vectors++; if (mem_we !== 1'b1 || mem_datain !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rstwr_grant: got we %b data %h want 1/cafef00d", mem_we, mem_datain); end
        tick();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rstwr_idle: got we %b stall %b want 0/0", mem_we, cpu_stall); end
        vectors++; if (ram[7] !== exp_mem[7]) begin miscompares++; $display("FAIL rstwr_ram: got %h want %h", ram[7], exp_mem[7]); end
        tick();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 32'h10000000 + 32'(i);
            exp_mem[i] = 32'h10000000 + 32'(i);
        end
        ram[4] = 32'hDEADBEEF; exp_mem[4] = 32'hDEADBEEF;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_priority();
        test_starvation();
        test_back_to_back();
        test_dropped_request();
        test_reset_in_busy_dma();
        test_reset_write_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
